// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the architectural PC, fetches one instruction at a time
// over a req/gnt/rvalid memory handshake and hands it to decode over valid/ready.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] pc,
   output logic        fetch_misaligned,
   output logic [31:0] fetch_count
);

   typedef enum logic [2:0] {
      ST_RESET,
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_ERROR
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        ifValid_q, ifValid_d;
   logic [31:0] ifInstr_q, ifInstr_d;
   logic [31:0] ifPc_q, ifPc_d;
   logic        misaligned_q, misaligned_d;
   logic [31:0] fetchCount_q, fetchCount_d;
   logic        outstanding_q, outstanding_d;

   // State register; reset wins over everything, including an in-flight fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RESET;
         pc_q          <= RESET_VECTOR;
         ifValid_q     <= 1'b0;
         ifInstr_q     <= NOP_INSTR;
         ifPc_q        <= 32'h0000_0000;
         misaligned_q  <= 1'b0;
         fetchCount_q  <= 32'h0000_0000;
         outstanding_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ifValid_q     <= ifValid_d;
         ifInstr_q     <= ifInstr_d;
         ifPc_q        <= ifPc_d;
         misaligned_q  <= misaligned_d;
         fetchCount_q  <= fetchCount_d;
         outstanding_q <= outstanding_d;
      end
   end

   // Next-state logic: rvalid only counts when it answers our own request.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ifValid_d     = ifValid_q;
      ifInstr_d     = ifInstr_q;
      ifPc_d        = ifPc_q;
      misaligned_d  = misaligned_q;
      fetchCount_d  = fetchCount_q;
      outstanding_d = outstanding_q;

      case (state_q)
         ST_RESET: state_d = ST_REQ;
         ST_REQ: begin
            if (imem_gnt) begin
               if (imem_rvalid) begin
                  ifInstr_d = imem_rdata;
                  ifPc_d    = pc_q;
                  ifValid_d = 1'b1;
                  state_d   = ST_HOLD;
               end else begin
                  outstanding_d = 1'b1;
                  state_d       = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (imem_rvalid && outstanding_q) begin
               ifInstr_d     = imem_rdata;
               ifPc_d        = pc_q;
               ifValid_d     = 1'b1;
               outstanding_d = 1'b0;
               state_d       = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (ifValid_q && if_ready) begin
               fetchCount_d = fetchCount_q + 32'd1;
               ifValid_d    = 1'b0;
               ifInstr_d    = NOP_INSTR;
               // A misaligned target is fatal: the PC is frozen until reset.
               if (pc_next[1:0] == 2'b00) begin
                  pc_d    = pc_next;
                  state_d = ST_REQ;
               end else begin
                  misaligned_d = 1'b1;
                  state_d      = ST_ERROR;
               end
            end
         end
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_RESET;
      endcase
   end

   assign imem_req         = (state_q == ST_REQ);
   assign imem_addr        = pc_q;
   assign pc               = pc_q;
   assign if_valid         = ifValid_q;
   assign if_instr         = ifInstr_q;
   assign if_pc            = ifPc_q;
   assign fetch_misaligned = misaligned_q;
   assign fetch_count      = fetchCount_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: random memory latencies and decode stalls
// checked against a transaction-level model of PC, retire count and error flag.
module tb_instr_fetch_unit;

   localparam logic [31:0] RV  = 32'h0000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] pc;
   logic        fetch_misaligned;
   logic [31:0] fetch_count;

   int checkCount = 0;
   int passCount  = 0;

   logic [31:0] modelPc;
   logic [31:0] modelCount;
   logic        modelMis;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .pc_next(pc_next),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .pc(pc), .fetch_misaligned(fetch_misaligned), .fetch_count(fetch_count)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [31:0] randAligned();
      logic [31:0] r;
      r = $urandom;
      return r & 32'hFFFF_FFFC;
   endfunction

   // Reset and check every architectural output; leaves the DUT in its first fetch request.
   task automatic applyReset();
      rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0;
      tick();
      rst = 1'b0;
      modelPc = RV; modelCount = 32'd0; modelMis = 1'b0;
      checkOutput("rstPc",    pc,               RV);
      checkOutput("rstReq",   imem_req,         0);
      checkOutput("rstValid", if_valid,         0);
      checkOutput("rstInstr", if_instr,         NOP);
      checkOutput("rstIfPc",  if_pc,            0);
      checkOutput("rstMis",   fetch_misaligned, 0);
      checkOutput("rstCount", fetch_count,      0);
      tick();
   endtask

   // One complete fetch-to-retire transaction. rvDelay==0 means rvalid together with gnt.
   task automatic applyStimulus(input int gntDelay, input int rvDelay, input int readyDelay,
                                input logic [31:0] nextPc, input logic [31:0] word);
      checkOutput("reqHigh", imem_req,  1);
      checkOutput("reqAddr", imem_addr, modelPc);
      for (int i = 0; i < gntDelay; i++) begin
         imem_gnt = 1'b0; imem_rvalid = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
         tick();
         checkOutput("reqHeld", imem_req, 1);
         checkOutput("reqNoValid", if_valid, 0);
      end
      imem_gnt    = 1'b1;
      imem_rvalid = (rvDelay == 0);
      imem_rdata  = (rvDelay == 0) ? word : $urandom;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      if (rvDelay > 0) begin
         for (int i = 0; i < rvDelay - 1; i++) begin
            checkOutput("waitReqLow", imem_req, 0);
            checkOutput("waitNoValid", if_valid, 0);
            imem_gnt = 1'($urandom_range(0, 1));
            tick();
         end
         checkOutput("waitReqLow", imem_req, 0);
         imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = word;
         tick();
         imem_rvalid = 1'b0;
      end
      checkOutput("holdValid", if_valid, 1);
      checkOutput("holdInstr", if_instr, word);
      checkOutput("holdIfPc",  if_pc,    modelPc);
      checkOutput("holdReq",   imem_req, 0);
      for (int i = 0; i < readyDelay; i++) begin
         if_ready = 1'b0; pc_next = $urandom;
         imem_rvalid = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
         tick();
         checkOutput("stallInstr", if_instr,    word);
         checkOutput("stallIfPc",  if_pc,       modelPc);
         checkOutput("stallPc",    pc,          modelPc);
         checkOutput("stallCount", fetch_count, modelCount);
      end
      imem_rvalid = 1'b0; if_ready = 1'b1; pc_next = nextPc;
      tick();
      if_ready = 1'b0;
      modelCount = modelCount + 32'd1;
      if (nextPc[1:0] == 2'b00) modelPc = nextPc;
      else modelMis = 1'b1;
      checkOutput("retCount", fetch_count,      modelCount);
      checkOutput("retMis",   fetch_misaligned, modelMis);
      checkOutput("retValid", if_valid,         0);
      checkOutput("retInstr", if_instr,         NOP);
      checkOutput("retPc",    pc,               modelPc);
      checkOutput("retReq",   imem_req,         !modelMis);
   endtask

   initial begin
      rst = 1'b1; pc_next = 32'd0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
      imem_rdata = 32'd0; if_ready = 1'b0;
      modelPc = RV; modelCount = 32'd0; modelMis = 1'b0;
      @(negedge clk);

      applyReset();
      applyStimulus(0, 0, 0, 32'h4, 32'h0050_0093);
      applyStimulus(2, 3, 0, randAligned(), $urandom);
      applyStimulus(0, 1, 5, 32'h100, $urandom);
      for (int n = 0; n < 8; n++)
         applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), randAligned(), $urandom);
      applyStimulus(1, 0, 0, 32'hFFFF_FFFC, $urandom);
      applyStimulus(0, 2, 1, 32'h0000_0008, $urandom);

      // Preload the retire counter just below wrap.
      force dut.fetchCount_q = 32'hFFFF_FFFF;
      #1;
      release dut.fetchCount_q;
      modelCount = 32'hFFFF_FFFF;
      applyStimulus(0, 0, 0, randAligned(), $urandom);
      checkOutput("wrapZero", fetch_count, 32'd0);

      applyStimulus(0, 1, 1, 32'h102, $urandom);
      for (int i = 0; i < 4; i++) begin
         imem_gnt = 1'($urandom_range(0, 1)); imem_rvalid = 1'b1; imem_rdata = $urandom;
         if_ready = 1'b1; pc_next = randAligned();
         tick();
         checkOutput("errReq",   imem_req,         0);
         checkOutput("errValid", if_valid,         0);
         checkOutput("errPc",    pc,               modelPc);
         checkOutput("errMis",   fetch_misaligned, 1);
         checkOutput("errCount", fetch_count,      modelCount);
      end
      imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0;
      applyReset();
      applyStimulus(0, 0, 2, 32'h20, $urandom);

      // Reset while a fetch is outstanding; the late rvalid must be dropped.
      imem_gnt = 1'b1; imem_rvalid = 1'b0;
      tick();
      imem_gnt = 1'b0;
      checkOutput("staleWait", imem_req, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      modelPc = RV; modelCount = 32'd0; modelMis = 1'b0;
      tick();
      checkOutput("staleValid", if_valid,  0);
      checkOutput("staleReq",   imem_req,  1);
      checkOutput("staleAddr",  imem_addr, RV);
      tick();
      imem_rvalid = 1'b0;
      checkOutput("staleValid2", if_valid, 0);
      checkOutput("staleInstr",  if_instr, NOP);
      applyStimulus(1, 1, 0, 32'h40, $urandom);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer end of the next-PC path. Holds the architectural program counter and loads it from the next-PC selector's output. Uses the PC to issue instruction-memory fetches over a req/gnt/rvalid handshake.
- Presents each fetched instruction to decode over a valid/ready handshake.
- Sits between the next-PC selector and the decode stage of the single-cycle core.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr whenever no instruction is valid (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- pc_next  input  32  next PC from the next-PC selector; sampled only on the decode handshake
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch byte address; always equals pc
- imem_gnt  input  1  memory accepts the request this cycle
- imem_rvalid  input  1  read data valid
- imem_rdata  input  32  instruction word
- if_valid  output  1  if_instr/if_pc hold a valid instruction
- if_ready  input  1  decode consumes the instruction this cycle
- if_instr  output  32  fetched instruction (registered)
- if_pc  output  32  address of if_instr
- pc  output  32  current PC register
- fetch_misaligned  output  1  sticky: pc_next had [1:0]!=0
- fetch_count  output  32  number of instructions retired via the decode handshake

Behaviour:
- Reset (rst=1 at a clock edge) forces the following, regardless of state, including mid-WAIT/HOLD:
  - pc=RESET_VECTOR, state=RESET, imem_req=0
  - if_valid=0, if_instr=NOP_INSTR, if_pc=0
  - fetch_misaligned=0, fetch_count=0, outstanding flag cleared
- FSM states: RESET, REQ, WAIT, HOLD, ERROR.
- RESET: next cycle -> REQ.
- REQ:
  - imem_req=1, imem_addr=pc.
  - gnt=0: stay.
  - gnt=1 and rvalid=0 -> WAIT, with the outstanding flag set.
  - gnt=1 and rvalid=1 in the same cycle (zero-latency memory): capture rdata and go directly -> HOLD.
- WAIT:
  - imem_req=0.
  - On rvalid: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, clear outstanding -> HOLD.
  - No timeout; stays in WAIT indefinitely.
- HOLD:
  - if_valid=1; if_instr and if_pc stable while if_ready=0.
  - On if_valid&&if_ready:
    - fetch_count+=1, wrapping mod 2^32.
    - if_valid<=0, if_instr<=NOP_INSTR.
    - If pc_next[1:0]==0: pc<=pc_next -> REQ.
    - Else: fetch_misaligned<=1, pc unchanged -> ERROR.
- ERROR: imem_req=0, if_valid=0. Exit only via rst.
- Spurious traffic:
  - imem_rvalid while the outstanding flag is clear (REQ without gnt, HOLD, ERROR, RESET) is ignored.
  - imem_gnt while imem_req=0 is ignored.
- Latency and throughput:
  - With gnt and rvalid in the same cycle and if_ready=1: 1 instruction per 2 cycles (REQ, HOLD).
  - With 1-cycle rvalid latency: 1 instruction per 3 cycles.
- At most one outstanding fetch at any time.
- pc changes only on a decode handshake or on reset.
- pc wrap: pc_next=32'hFFFF_FFFC is legal. No arithmetic inside the block; pc_next is used as given.

Test Plan:
- Reset release, memory gnt and rvalid in the same cycle returning 32'h00500093, if_ready=1 -> REQ at addr 0. Next cycle: if_valid=1, if_instr=32'h00500093, if_pc=0. On handshake with pc_next=4: fetch_count=1, next REQ addr=4.
- gnt after 2 cycles, rvalid 3 cycles after gnt -> imem_req held high until gnt, low during WAIT. if_valid asserts the cycle after rvalid.
- HOLD with if_ready=0 for 5 cycles, pc_next toggling -> if_instr, if_pc and pc stable; fetch_count unchanged. if_ready=1 with pc_next=32'h100 -> next imem_addr=32'h100.
- Handshake with pc_next=32'h102 -> fetch_misaligned=1, ERROR state, imem_req stays 0, pc unchanged. rst -> all outputs return to reset values.
- rst asserted in WAIT; a stale rvalid arrives 1 cycle after rst is released -> ignored. if_valid stays 0 and a fresh REQ to RESET_VECTOR is issued.
- 2^32-wrap check with fetch_count preloaded via force to 32'hFFFF_FFFF -> one more handshake gives 0.
